keypad_entry_fsm: RTL
=====================

// Module: keypad_entry_fsm
// PURPOSE
//  Parametrised successor to the combinational keycode decoder. Sits between the keypad scanner and the ALU.
//  Edge-detects keystrobe and decodes keycode: 0-9 digit, 10 clear, 11 execute, 12-15 operator.
//  Accumulates decimal digits into a signed binary operand, supports a leading unary minus,
//  and emits registered, single-cycle strobes for operand, operator, execute and clear.
// PARAMETERS
//  DATA_W      16  operand width, two's complement; must satisfy 10**MAX_DIGITS-1 <= 2**(DATA_W-1)-1
//  MAX_DIGITS   4  maximum digits per operand; further digits are dropped
//  ALLOW_NEG    1  1: '-' (code 14) pressed with no digits entered toggles the sign; 0: it is a normal operator
// PORTS
//  clk            in   1       system clock, rising edge
//  rst_n          in   1       asynchronous active-low reset
//  keystrobe      in   1       level, high while a key is held (may span many cycles)
//  keycode        in   4       key code, valid whenever keystrobe is high
//  operand        out  DATA_W  signed operand, valid in the cycle operand_valid=1
//  operand_valid  out  1       1-cycle pulse: an entered operand completes (on operator or execute)
//  op_valid       out  1       1-cycle pulse: operator key accepted
//  op_code        out  2       ~keycode[1:0]: +=0, -=1, *=2, /=3; held until the next op_valid
//  ex_valid       out  1       1-cycle pulse: execute key (code 11)
//  clr_valid      out  1       1-cycle pulse: clear key (code 10)
//  negative       out  1       sign pending for the current entry (display)
//  digit_count    out  clog2(MAX_DIGITS+1)  digits entered so far
//  entry_ovf      out  1       sticky: a digit was dropped at MAX_DIGITS; cleared by clear/operator/execute
// BEHAVIOUR
//  Reset: all outputs 0; state EMPTY; value 0; key_prev=1, so a key held through reset release is not a press.
//  Press event: keystrobe & ~key_prev. keycode is sampled in that cycle (N). Every output updates at edge N+1.
//  Held keys produce exactly one event. Keycode changes while keystrobe stays high are ignored.
//  All pulse outputs are registered and high for exactly one cycle.
//  EMPTY (no digits entered):
//    digit d   -> value=d, count=1, go ENTRY. A leading 0 is accepted and counted.
//    code 14, ALLOW_NEG=1 -> negative toggles; no strobe.
//    operator  -> op_valid=1, op_code updated, operand_valid=0 (operator applies to the previous result).
//    execute   -> ex_valid=1, operand_valid=0.
//  ENTRY:
//    digit, count<MAX_DIGITS  -> value=value*10+d, count++.
//    digit, count==MAX_DIGITS -> digit dropped, entry_ovf=1.
//    operator -> operand_valid=1 and op_valid=1 in the same cycle; operand = negative ? -value : value.
//                Then go EMPTY: value=0, count=0, negative=0, entry_ovf=0.
//    execute  -> operand_valid=1 and ex_valid=1; same operand and EMPTY return as operator.
//  Clear (any state): clr_valid=1, return to EMPTY, value/count/negative/entry_ovf=0. op_code holds.
//  operand holds its last value between pulses.
//  value*10+d is computed at DATA_W+4 bits and truncated. The parameter constraint rules out overflow.
//  rst_n low mid-entry: immediate return to reset values; a pulse in flight is cancelled.
// TESTING
//  1 keystrobe held 20 cycles, code 7 -> one event only: count=1, no pulses.
//  2 keys 1,2,3 then 15 (+) -> one cycle: operand=123, operand_valid=1, op_valid=1, op_code=0; count->0.
//  3 ALLOW_NEG=1: keys 14,4,5,11 -> operand=-45 (0xFFD3 at DATA_W=16), operand_valid=1, ex_valid=1.
//  4 MAX_DIGITS=4: keys 9,9,9,9,9 -> value 9999, entry_ovf=1; then key 12 -> operand=9999, op_code=3, entry_ovf=0.
//  5 keys 5,6 then 10 -> clr_valid=1, count=0, no operand_valid; then key 13 in EMPTY -> op_valid=1, op_code=2, operand_valid=0.
//  6 rst_n low for 1 cycle after keys 8,8 with keystrobe still high -> outputs 0, no event until keystrobe drops and rises again.

Source files
------------

// File: rtl/keypad_entry_fsm.sv
// keypad_entry_fsm
//   Sits between the keypad scanner and the ALU. Detects rising edges of the
//   keystrobe level, decodes the 4-bit keycode (0-9 digit, 10 clear,
//   11 execute, 12-15 operator) and builds a signed decimal operand with an
//   optional leading unary minus. All results are registered and every strobe
//   is a single-cycle pulse.
//
// Ports
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   keystrobe      in   high while a key is held
//   keycode        in   key code, valid while keystrobe is high
//   operand        out  signed operand, valid while operand_valid=1, held otherwise
//   operand_valid  out  pulse: an entered operand completed
//   op_valid       out  pulse: operator key accepted
//   op_code        out  +=0 -=1 *=2 /=3, held until the next op_valid
//   ex_valid       out  pulse: execute key
//   clr_valid      out  pulse: clear key
//   negative       out  sign pending for the current entry
//   digit_count    out  digits entered so far
//   entry_ovf      out  sticky: a digit was dropped because the entry was full
module keypad_entry_fsm #(
  parameter int DATA_W     = 16,
  parameter int MAX_DIGITS = 4,
  parameter int ALLOW_NEG  = 1,
  localparam int CNT_W     = $clog2(MAX_DIGITS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              keystrobe,
  input  logic [3:0]        keycode,
  output logic [DATA_W-1:0] operand,
  output logic              operand_valid,
  output logic              op_valid,
  output logic [1:0]        op_code,
  output logic              ex_valid,
  output logic              clr_valid,
  output logic              negative,
  output logic [CNT_W-1:0]  digit_count,
  output logic              entry_ovf
);

  typedef enum logic {
    EMPTY = 1'b0,
    ENTRY = 1'b1
  } state_t;

  state_t              state_reg, state_next;
  logic                key_prev_reg;
  logic [DATA_W-1:0]   value_reg, value_next;
  logic [CNT_W-1:0]    count_reg, count_next;
  logic                neg_reg, neg_next;
  logic                ovf_reg, ovf_next;
  logic [DATA_W-1:0]   operand_reg, operand_next;
  logic [1:0]          op_code_reg, op_code_next;
  logic                operand_valid_reg, operand_valid_next;
  logic                op_valid_reg, op_valid_next;
  logic                ex_valid_reg, ex_valid_next;
  logic                clr_valid_reg, clr_valid_next;

  logic press;
  logic is_digit, is_clear, is_exec, is_op, is_sign;

  // key_prev resets to 1 so a key still held when reset releases is not a press.
  assign press    = keystrobe & ~key_prev_reg;
  assign is_digit = (keycode <= 4'd9);
  assign is_clear = (keycode == 4'd10);
  assign is_exec  = (keycode == 4'd11);
  assign is_op    = (keycode >= 4'd12);
  // Code 14 with no digits yet acts as a unary minus instead of an operator.
  assign is_sign  = (ALLOW_NEG != 0) && (keycode == 4'd14) && (state_reg == EMPTY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= EMPTY;
      key_prev_reg      <= 1'b1;
      value_reg         <= '0;
      count_reg         <= '0;
      neg_reg           <= 1'b0;
      ovf_reg           <= 1'b0;
      operand_reg       <= '0;
      op_code_reg       <= '0;
      operand_valid_reg <= 1'b0;
      op_valid_reg      <= 1'b0;
      ex_valid_reg      <= 1'b0;
      clr_valid_reg     <= 1'b0;
    end else begin
      state_reg         <= state_next;
      key_prev_reg      <= keystrobe;
      value_reg         <= value_next;
      count_reg         <= count_next;
      neg_reg           <= neg_next;
      ovf_reg           <= ovf_next;
      operand_reg       <= operand_next;
      op_code_reg       <= op_code_next;
      operand_valid_reg <= operand_valid_next;
      op_valid_reg      <= op_valid_next;
      ex_valid_reg      <= ex_valid_next;
      clr_valid_reg     <= clr_valid_next;
    end
  end

  always_comb begin
    state_next         = state_reg;
    value_next         = value_reg;
    count_next         = count_reg;
    neg_next           = neg_reg;
    ovf_next           = ovf_reg;
    operand_next       = operand_reg;
    op_code_next       = op_code_reg;
    operand_valid_next = 1'b0;
    op_valid_next      = 1'b0;
    ex_valid_next      = 1'b0;
    clr_valid_next     = 1'b0;

    if (press) begin
      if (is_digit) begin
        if (state_reg == EMPTY) begin
          value_next = {{(DATA_W-4){1'b0}}, keycode};
          count_next = CNT_W'(1);
          state_next = ENTRY;
        end else if (count_reg < CNT_W'(MAX_DIGITS)) begin
          // value*10 + d; the low DATA_W bits are identical to the result of
          // the wider computation, and the parameter constraint keeps the
          // accumulated value in range anyway.
          value_next = (value_reg << 3) + (value_reg << 1) + DATA_W'(keycode);
          count_next = count_reg + CNT_W'(1);
        end else begin
          ovf_next = 1'b1;
        end
      end else if (is_clear) begin
        clr_valid_next = 1'b1;
        state_next     = EMPTY;
        value_next     = '0;
        count_next     = '0;
        neg_next       = 1'b0;
        ovf_next       = 1'b0;
      end else if (is_sign) begin
        neg_next = ~neg_reg;
      end else if (is_exec || is_op) begin
        if (state_reg == ENTRY) begin
          operand_valid_next = 1'b1;
          operand_next       = neg_reg ? (~value_reg + DATA_W'(1)) : value_reg;
        end
        if (is_op) begin
          op_valid_next = 1'b1;
          op_code_next  = ~keycode[1:0];
        end else begin
          ex_valid_next = 1'b1;
        end
        state_next = EMPTY;
        value_next = '0;
        count_next = '0;
        neg_next   = 1'b0;
        ovf_next   = 1'b0;
      end
    end
  end

  assign operand       = operand_reg;
  assign operand_valid = operand_valid_reg;
  assign op_valid      = op_valid_reg;
  assign op_code       = op_code_reg;
  assign ex_valid      = ex_valid_reg;
  assign clr_valid     = clr_valid_reg;
  assign negative      = neg_reg;
  assign digit_count   = count_reg;
  assign entry_ovf     = ovf_reg;

endmodule
